// File: rtl/if_id_pipe_reg_pkg.sv
// Shared IF/ID pipeline types and constants.
package mips_pipe_pkg;

   localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
   localparam logic [31:0] BOOT_VECTOR = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DSLOT  = 2'd1,
      SQUASH = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        dslot;
   } if_id_t;

   // A bubble still carries the fetch PC+4 so ID sees a consistent address.
   function automatic if_id_t make_bubble(input logic [31:0] nop, input logic [31:0] pc4);
      if_id_t b;
      b.instr = nop;
      b.pc4   = pc4;
      b.valid = 1'b0;
      b.dslot = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch/hazard-side inputs and ID-side outputs of the IF/ID register.
interface if_id_pipe_reg_if #(
   parameter int MISS_CNT_W = 8
);
   logic                  STALL;
   logic                  FLUSH;
   logic [31:0]           Instruction_IN;
   logic                  InstructionValid_IN;
   logic [31:0]           InstructionAddressPlus4_IN;
   logic                  AltPCEnable_IN;
   logic [31:0]           Instruction_OUT;
   logic [31:0]           InstructionAddressPlus4_OUT;
   logic                  Valid_OUT;
   logic                  InDelaySlot_OUT;
   logic [MISS_CNT_W-1:0] MissCount_OUT;

   modport master (
      output STALL, FLUSH, Instruction_IN, InstructionValid_IN,
             InstructionAddressPlus4_IN, AltPCEnable_IN,
      input  Instruction_OUT, InstructionAddressPlus4_OUT, Valid_OUT,
             InDelaySlot_OUT, MissCount_OUT
   );

   modport slave (
      input  STALL, FLUSH, Instruction_IN, InstructionValid_IN,
             InstructionAddressPlus4_IN, AltPCEnable_IN,
      output Instruction_OUT, InstructionAddressPlus4_OUT, Valid_OUT,
             InDelaySlot_OUT, MissCount_OUT
   );
endinterface

// File: rtl/if_id_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear and hold.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, stick at all-ones, clear has priority.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with stall/flush, IM-miss bubbles and
// delay-slot tagging / wrong-path squash after a taken branch.
//
// state  | meaning
// RUN    | normal loading; a taken branch held in ID arms DSLOT
// DSLOT  | delay slot held; next valid fetch is wrong-path, squash it
// SQUASH | bubble held; next valid fetch is the branch target
module if_id_pipe_reg #(
   parameter logic [31:0] NOP_WORD   = mips_pipe_pkg::NOP_WORD,
   parameter logic [31:0] RESET_PC4  = mips_pipe_pkg::BOOT_VECTOR + 32'd4,
   parameter int          MISS_CNT_W = 8
) (
   input  logic             CLOCK,
   input  logic             RESET,
   if_id_pipe_reg_if.slave  bus
);
   import mips_pipe_pkg::*;

   if_id_t                cur_q;
   if_id_t                cur_nxt;
   state_t                state_q;
   state_t                state_nxt;
   logic                  miss_inc;
   logic [MISS_CNT_W-1:0] miss_count;

   // Next contents and state; priority FLUSH > STALL > load.
   always_comb begin
      cur_nxt   = cur_q;
      state_nxt = state_q;
      miss_inc  = 1'b0;
      if (bus.FLUSH) begin
         cur_nxt   = make_bubble(NOP_WORD, bus.InstructionAddressPlus4_IN);
         state_nxt = RUN;
      end else if (!bus.STALL) begin
         if (!bus.InstructionValid_IN) begin
            // IM miss: bubble, but any pending squash stays pending.
            cur_nxt  = make_bubble(NOP_WORD, bus.InstructionAddressPlus4_IN);
            miss_inc = 1'b1;
         end else begin
            case (state_q)
               RUN: begin
                  cur_nxt.instr = bus.Instruction_IN;
                  cur_nxt.pc4   = bus.InstructionAddressPlus4_IN;
                  cur_nxt.valid = 1'b1;
                  cur_nxt.dslot = bus.AltPCEnable_IN && cur_q.valid;
                  if (bus.AltPCEnable_IN && cur_q.valid) begin
                     state_nxt = DSLOT;
                  end
               end
               DSLOT: begin
                  cur_nxt   = make_bubble(NOP_WORD, bus.InstructionAddressPlus4_IN);
                  state_nxt = SQUASH;
               end
               SQUASH: begin
                  cur_nxt.instr = bus.Instruction_IN;
                  cur_nxt.pc4   = bus.InstructionAddressPlus4_IN;
                  cur_nxt.valid = 1'b1;
                  cur_nxt.dslot = 1'b0;
                  state_nxt     = RUN;
               end
               default: begin
                  cur_nxt   = make_bubble(NOP_WORD, bus.InstructionAddressPlus4_IN);
                  state_nxt = RUN;
               end
            endcase
         end
      end
   end

   // Register the IF/ID bundle and FSM state.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         cur_q   <= make_bubble(NOP_WORD, RESET_PC4);
         state_q <= RUN;
      end else begin
         cur_q   <= cur_nxt;
         state_q <= state_nxt;
      end
   end

   sat_counter #(.W(MISS_CNT_W)) u_miss_cnt (
      .clk   (CLOCK),
      .rst   (RESET),
      .clear (1'b0),
      .inc   (miss_inc),
      .count (miss_count)
   );

   assign bus.Instruction_OUT             = cur_q.instr;
   assign bus.InstructionAddressPlus4_OUT = cur_q.pc4;
   assign bus.Valid_OUT                   = cur_q.valid;
   assign bus.InDelaySlot_OUT             = cur_q.dslot;
   assign bus.MissCount_OUT               = miss_count;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed table-driven bench for the IF/ID pipeline register.
module tb_if_id_pipe_reg;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        flush;
      logic [31:0] instr;
      logic        iv;
      logic [31:0] pc4;
      logic        alt;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_v;
      logic        e_ds;
      logic [7:0]  e_miss;
   } vec_t;

   localparam int NVEC = 24;

   logic CLOCK;
   logic RESET;
   int   n_vec;
   int   n_bad;
   vec_t vecs [NVEC];

   if_id_pipe_reg_if #(.MISS_CNT_W(8)) bus ();

   if_id_pipe_reg #(.MISS_CNT_W(8)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   function automatic vec_t mk(input logic r, input logic s, input logic f,
                               input logic [31:0] ins, input logic iv,
                               input logic [31:0] pc, input logic alt,
                               input logic [31:0] ei, input logic [31:0] ep,
                               input logic ev, input logic eds, input logic [7:0] em);
      vec_t v;
      v.rst = r; v.stall = s; v.flush = f; v.instr = ins; v.iv = iv;
      v.pc4 = pc; v.alt = alt; v.e_instr = ei; v.e_pc4 = ep;
      v.e_v = ev; v.e_ds = eds; v.e_miss = em;
      return v;
   endfunction

   task automatic drive(input logic r, input logic s, input logic f,
                        input logic [31:0] ins, input logic iv,
                        input logic [31:0] pc, input logic alt);
      RESET                          = r;
      bus.STALL                      = s;
      bus.FLUSH                      = f;
      bus.Instruction_IN             = ins;
      bus.InstructionValid_IN        = iv;
      bus.InstructionAddressPlus4_IN = pc;
      bus.AltPCEnable_IN             = alt;
   endtask

   task automatic check(input string name, input logic [31:0] ei, input logic [31:0] ep,
                        input logic ev, input logic eds, input logic [7:0] em);
      n_vec++;
      if (bus.Instruction_OUT !== ei || bus.InstructionAddressPlus4_OUT !== ep ||
          bus.Valid_OUT !== ev || bus.InDelaySlot_OUT !== eds || bus.MissCount_OUT !== em) begin
         n_bad++;
         $display("FAIL %s: got instr=%h pc4=%h valid=%b dslot=%b miss=%0d, want instr=%h pc4=%h valid=%b dslot=%b miss=%0d",
                  name, bus.Instruction_OUT, bus.InstructionAddressPlus4_OUT, bus.Valid_OUT,
                  bus.InDelaySlot_OUT, bus.MissCount_OUT, ei, ep, ev, eds, em);
      end
   endtask

   // Apply one input set before the edge, check just after it.
   task automatic step(input logic r, input logic s, input logic f,
                       input logic [31:0] ins, input logic iv,
                       input logic [31:0] pc, input logic alt);
      @(negedge CLOCK);
      drive(r, s, f, ins, iv, pc, alt);
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      //             rst  stl  fls  instr         iv   pc4           alt   e_instr       e_pc4         v    ds   miss
      vecs[0]  = mk(1'b1,1'b0,1'b0,32'hAAAA_AAAA,1'b1,32'h0000_1234,1'b1, 32'h0000_0000,32'hBFC0_0004,1'b0,1'b0,8'd0);
      vecs[1]  = mk(1'b0,1'b0,1'b0,32'h2008_0005,1'b1,32'hBFC0_0004,1'b0, 32'h2008_0005,32'hBFC0_0004,1'b1,1'b0,8'd0);
      vecs[2]  = mk(1'b0,1'b1,1'b0,32'h1111_1111,1'b1,32'h0000_0008,1'b1, 32'h2008_0005,32'hBFC0_0004,1'b1,1'b0,8'd0);
      vecs[3]  = mk(1'b0,1'b1,1'b0,32'h2222_2222,1'b0,32'h0000_000C,1'b0, 32'h2008_0005,32'hBFC0_0004,1'b1,1'b0,8'd0);
      vecs[4]  = mk(1'b0,1'b1,1'b0,32'h3333_3333,1'b1,32'h0000_0010,1'b0, 32'h2008_0005,32'hBFC0_0004,1'b1,1'b0,8'd0);
      vecs[5]  = mk(1'b0,1'b1,1'b1,32'h4444_4444,1'b1,32'hBFC0_0008,1'b0, 32'h0000_0000,32'hBFC0_0008,1'b0,1'b0,8'd0);
      vecs[6]  = mk(1'b0,1'b0,1'b0,32'h1080_0003,1'b1,32'hBFC0_000C,1'b0, 32'h1080_0003,32'hBFC0_000C,1'b1,1'b0,8'd0);
      vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0000_0020,1'b1,32'hBFC0_0010,1'b1, 32'h0000_0020,32'hBFC0_0010,1'b1,1'b1,8'd0);
      vecs[8]  = mk(1'b0,1'b0,1'b0,32'hDEAD_BEEF,1'b1,32'hBFC0_0014,1'b1, 32'h0000_0000,32'hBFC0_0014,1'b0,1'b0,8'd0);
      vecs[9]  = mk(1'b0,1'b0,1'b0,32'h8C09_0000,1'b1,32'hBFC0_0100,1'b1, 32'h8C09_0000,32'hBFC0_0100,1'b1,1'b0,8'd0);
      vecs[10] = mk(1'b0,1'b0,1'b0,32'h0109_5020,1'b1,32'hBFC0_0104,1'b0, 32'h0109_5020,32'hBFC0_0104,1'b1,1'b0,8'd0);
      vecs[11] = mk(1'b0,1'b0,1'b0,32'h5555_5555,1'b0,32'hBFC0_0108,1'b0, 32'h0000_0000,32'hBFC0_0108,1'b0,1'b0,8'd1);
      vecs[12] = mk(1'b0,1'b0,1'b0,32'h1000_0004,1'b1,32'hBFC0_010C,1'b0, 32'h1000_0004,32'hBFC0_010C,1'b1,1'b0,8'd1);
      vecs[13] = mk(1'b0,1'b0,1'b0,32'h2402_0001,1'b1,32'hBFC0_0110,1'b1, 32'h2402_0001,32'hBFC0_0110,1'b1,1'b1,8'd1);
      vecs[14] = mk(1'b0,1'b0,1'b0,32'h6666_6666,1'b0,32'hBFC0_0114,1'b0, 32'h0000_0000,32'hBFC0_0114,1'b0,1'b0,8'd2);
      vecs[15] = mk(1'b0,1'b0,1'b0,32'hCAFE_F00D,1'b1,32'hBFC0_0118,1'b0, 32'h0000_0000,32'hBFC0_0118,1'b0,1'b0,8'd2);
      vecs[16] = mk(1'b1,1'b0,1'b0,32'h7777_7777,1'b1,32'hBFC0_011C,1'b0, 32'h0000_0000,32'hBFC0_0004,1'b0,1'b0,8'd0);
      vecs[17] = mk(1'b0,1'b0,1'b0,32'h1234_5678,1'b1,32'hBFC0_0008,1'b0, 32'h1234_5678,32'hBFC0_0008,1'b1,1'b0,8'd0);
      vecs[18] = mk(1'b0,1'b0,1'b0,32'h2403_0002,1'b1,32'hBFC0_000C,1'b1, 32'h2403_0002,32'hBFC0_000C,1'b1,1'b1,8'd0);
      vecs[19] = mk(1'b0,1'b0,1'b1,32'h9999_9999,1'b1,32'hBFC0_0200,1'b0, 32'h0000_0000,32'hBFC0_0200,1'b0,1'b0,8'd0);
      vecs[20] = mk(1'b0,1'b0,1'b0,32'h8C0A_0004,1'b1,32'hBFC0_0204,1'b0, 32'h8C0A_0004,32'hBFC0_0204,1'b1,1'b0,8'd0);
      vecs[21] = mk(1'b0,1'b0,1'b0,32'h8888_8888,1'b0,32'hBFC0_0208,1'b0, 32'h0000_0000,32'hBFC0_0208,1'b0,1'b0,8'd1);
      vecs[22] = mk(1'b0,1'b0,1'b0,32'h0000_0021,1'b1,32'hBFC0_020C,1'b1, 32'h0000_0021,32'hBFC0_020C,1'b1,1'b0,8'd1);
      vecs[23] = mk(1'b0,1'b0,1'b0,32'h0000_0022,1'b1,32'hBFC0_0210,1'b0, 32'h0000_0022,32'hBFC0_0210,1'b1,1'b0,8'd1);

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].instr,
              vecs[i].iv, vecs[i].pc4, vecs[i].alt);
         check($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc4,
               vecs[i].e_v, vecs[i].e_ds, vecs[i].e_miss);
      end

      // Long IM miss: miss counter saturates at 255, every cycle a bubble.
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("miss_rst", 32'h0, 32'hBFC0_0004, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 300; i++) begin
         logic [31:0] pc;
         pc = 32'hBFC0_1000 + 32'(i * 4);
         step(1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 1'b0, pc, 1'b0);
         check($sformatf("miss%0d", i), 32'h0, pc, 1'b0, 1'b0,
               (i + 1 >= 255) ? 8'd255 : 8'(i + 1));
      end
      step(1'b0, 1'b0, 1'b0, 32'h0123_4567, 1'b1, 32'hBFC0_2000, 1'b0);
      check("miss_after_sat", 32'h0123_4567, 32'hBFC0_2000, 1'b1, 1'b0, 8'd255);
      step(1'b0, 1'b1, 1'b0, 32'hEEEE_EEEE, 1'b0, 32'hBFC0_2004, 1'b0);
      check("stall_no_miss", 32'h0123_4567, 32'hBFC0_2000, 1'b1, 1'b0, 8'd255);

      // Several misses while the squash is pending, then a stall, then the squash.
      step(1'b0, 1'b0, 1'b0, 32'h2404_0003, 1'b1, 32'hBFC0_3000, 1'b1);
      check("ds_tag", 32'h2404_0003, 32'hBFC0_3000, 1'b1, 1'b1, 8'd255);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hBFC0_3004, 1'b0);
         check($sformatf("ds_miss%0d", i), 32'h0, 32'hBFC0_3004, 1'b0, 1'b0, 8'd255);
      end
      step(1'b0, 1'b1, 1'b0, 32'h5A5A_5A5A, 1'b1, 32'hBFC0_3008, 1'b0);
      check("ds_stall", 32'h0, 32'hBFC0_3004, 1'b0, 1'b0, 8'd255);
      step(1'b0, 1'b0, 1'b0, 32'hBAD0_BAD0, 1'b1, 32'hBFC0_3008, 1'b0);
      check("ds_squash", 32'h0, 32'hBFC0_3008, 1'b0, 1'b0, 8'd255);
      step(1'b0, 1'b0, 1'b0, 32'h0C00_0040, 1'b1, 32'hBFC0_4000, 1'b0);
      check("ds_target", 32'h0C00_0040, 32'hBFC0_4000, 1'b1, 1'b0, 8'd255);
      step(1'b0, 1'b0, 1'b0, 32'h0C00_0044, 1'b1, 32'hBFC0_4004, 1'b0);
      check("ds_after", 32'h0C00_0044, 32'hBFC0_4004, 1'b1, 1'b0, 8'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- IF/ID pipeline register directly downstream of the fetch stage. Captures the IM instruction word and the fetch PC+4 each cycle and presents them to ID.
- Applies STALL (hold) and FLUSH (kill). Inserts bubbles while IM has no valid word.
- Tags the MIPS branch-delay-slot instruction and squashes one wrong-path fetch after a taken branch, per the FSM below.

Parameters:
- NOP_WORD, 32'h0000_0000, instruction word emitted for a bubble (sll $0,$0,0).
- RESET_PC4, 32'hBFC0_0004, reset value of PC+4 output (boot vector + 4).
- MISS_CNT_W, 8, width of saturating IM-miss counter.

Ports:
- CLOCK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  hazard-unit hold; register contents frozen.
- FLUSH  in  1  kill current IF/ID contents (exception/redirect).
- Instruction_IN  in  32  IM read data for current fetch.
- InstructionValid_IN  in  1  IM data valid this cycle.
- InstructionAddressPlus4_IN  in  32  PC+4 from IF.
- AltPCEnable_IN  in  1  ID resolved taken branch/jump this cycle (same signal IF consumes).
- Instruction_OUT  out  32  instruction to ID.
- InstructionAddressPlus4_OUT  out  32  PC+4 to ID.
- Valid_OUT  out  1  1 = real instruction, 0 = bubble.
- InDelaySlot_OUT  out  1  held instruction is the delay slot of a taken branch.
- MissCount_OUT  out  MISS_CNT_W  saturating count of bubble cycles from IM misses.

Behaviour:
- Reset (RESET=1 at posedge): Instruction_OUT=NOP_WORD, InstructionAddressPlus4_OUT=RESET_PC4, Valid_OUT=0, InDelaySlot_OUT=0, MissCount_OUT=0, FSM=RUN. Reset overrides every other input.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Priority per edge: RESET > FLUSH > STALL > load.
- FLUSH: outputs become bubble (NOP_WORD, Valid_OUT=0, InDelaySlot_OUT=0). PC+4 output still loads the input. FSM goes to RUN. FLUSH overrides STALL.
- STALL (no FLUSH): all outputs and FSM state hold. AltPCEnable_IN is ignored, because ID is stalled too. The miss counter does not count.
- Load, InstructionValid_IN=0: bubble loaded. PC+4 loads. MissCount_OUT increments and saturates at all-ones. FSM state holds; a pending delay slot stays pending.
- Load, InstructionValid_IN=1: Instruction_IN and PC+4 load, and Valid_OUT=1, except where the FSM below overrides.
- FSM states RUN, DSLOT, SQUASH:
  - RUN: if AltPCEnable_IN=1 and Valid_OUT=1, go to DSLOT. The word loaded on this same edge is the delay slot: InDelaySlot_OUT=1 and it is kept.
  - DSLOT: on the next valid load, the word is the wrong-path fetch (IF redirects one edge later). Load a bubble and go to SQUASH.
  - SQUASH: the next valid load is the target instruction. Load it normally and return to RUN.
  - A new AltPCEnable_IN while in DSLOT/SQUASH is ignored (ID holds a delay slot or bubble).
- InDelaySlot_OUT is 1 only in the cycle the delay-slot word is held; it clears on any other load.
- Reset mid-sequence (in DSLOT/SQUASH) returns to RUN with no squash pending.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - NOP_WORD and the boot vector constant 32'hBFC0_0000;
  - the FSM state enum (RUN/DSLOT/SQUASH, 2 bits);
  - the IF/ID bundle struct (instr, pc4, valid, dslot).
- One sub-module is natural: sat_counter (parameterised width, inc/clear/hold), used for MissCount_OUT.

Test Plan:
- Reset, then reset release: outputs are NOP 0x0, PC4 0xBFC00004, Valid 0, Miss 0. First edge with Instruction_IN=0x20080005, valid, PC4=0xBFC00004 → Instruction_OUT=0x20080005, Valid=1.
- STALL held 3 cycles while inputs change: outputs stay unchanged. STALL+FLUSH on the same edge: bubble loaded.
- Taken branch: beq held, AltPCEnable=1 → next word 0x00000020 is loaded with InDelaySlot=1. Next fetch 0xDEADBEEF becomes a bubble (Valid=0). Target word 0x8C090000 loads with Valid=1.
- IM miss: valid=0 for 300 cycles → 300 bubbles and MissCount saturates at 255. Miss during DSLOT does not consume the squash; the squash applies to the first valid word afterwards.
- RESET asserted while in SQUASH → RUN. The next valid word loads without being squashed.
- FLUSH during DSLOT → bubble, FSM in RUN. The next valid word is kept with InDelaySlot=0.
